// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder: instruction field layout,
// opcode constants for building program words, and the feeder FSM states.
package instr_feeder_pkg;

  localparam int          IW_DEF        = 16;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;
  localparam int RY_MSB  = 8;
  localparam int RY_LSB  = 6;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_MV  = 4'h8;
  localparam logic [3:0] OP_MVI = 4'hA;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_HALTED
  } state_t;

  // Register-register form: op rx, ry
  function automatic logic [15:0] mk_rr(input logic [3:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry);
    logic [15:0] w;
    w                = '0;
    w[OP_MSB:OP_LSB] = op;
    w[RX_MSB:RX_LSB] = rx;
    w[RY_MSB:RY_LSB] = ry;
    return w;
  endfunction

  // Immediate form: op rx, #imm
  function automatic logic [15:0] mk_imm(input logic [3:0] op, input logic [2:0] rx,
                                         input logic [8:0] imm);
    logic [15:0] w;
    w                  = '0;
    w[OP_MSB:OP_LSB]   = op;
    w[RX_MSB:RX_LSB]   = rx;
    w[IMM_MSB:IMM_LSB] = imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Processor-side handshake of the instruction feeder: instruction word, run
// pulse, completion strobe and the processor bus value captured on completion.
interface instr_feeder_if
  import instr_feeder_pkg::*;
#(
  parameter int IW = IW_DEF
) ();

  logic [IW-1:0] iin;
  logic          run;
  logic          done;
  logic [15:0]   bus;

  modport master (output iin, output run, input done, input bus);
  modport slave  (input iin, input run, output done, output bus);

endinterface

// File: rtl/instr_feeder_program_ram.sv
// Program store: 2**AW x IW synchronous RAM with registered read. A write to
// the address being read in the same cycle returns the new word.
module instr_feeder_program_ram #(
  parameter int AW = 4,
  parameter int IW = 16
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  logic [IW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: issues preloaded program words to the processor one at a
// time (fetch, pulse run, wait for done) until halt word, program end or timeout.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int            AW        = 4,
  parameter int            IW        = IW_DEF,
  parameter logic [IW-1:0] HALT_WORD = IW'(HALT_WORD_DEF),
  parameter int            TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [IW-1:0]        wr_data,
  input  logic [AW:0]          prog_len,
  input  logic                 start,
  instr_feeder_if.master       proc,
  output logic [AW-1:0]        pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout,
  output logic [15:0]          last_bus
);

  localparam logic [AW:0] DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_d;
  logic [AW-1:0] pc_d;
  logic [AW:0]   len;
  logic [AW:0]   len_clamped;
  logic [7:0]    cnt;
  logic [IW-1:0] iin_q;
  logic [IW-1:0] rd_data;
  logic          start_ok;
  logic          last_pc;
  logic          cnt_expired;
  logic          is_halt;
  logic          ram_we;

  assign len_clamped = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_HALTED));
  assign last_pc     = ({1'b0, pc} == (len - (AW+1)'(1)));
  assign cnt_expired = (cnt == CNT_LAST);
  assign is_halt     = (rd_data == HALT_WORD);
  // Writes are locked out while a program runs and while reset is asserted.
  assign ram_we      = wr_en && !busy && !resetn;

  // The RAM reads the address pc will hold next, so the word is ready in FETCH.
  instr_feeder_program_ram #(
    .AW (AW),
    .IW (IW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (pc_d),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (resetn) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = (len_clamped == '0) ? ST_HALTED : ST_FETCH;
        end
      end
      ST_FETCH: state_d = is_halt ? ST_HALTED : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (proc.done) begin
          if (last_pc) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = pc + 1'b1;
            state_d = ST_FETCH;
          end
        end else if (cnt_expired) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT);
    halted   = (state == ST_HALTED);
    proc.run = (state == ST_ISSUE);
  end

  assign proc.iin = iin_q;

  always_ff @(posedge clock) begin
    if (resetn) begin
      pc       <= '0;
      len      <= '0;
      cnt      <= '0;
      iin_q    <= '0;
      timeout  <= 1'b0;
      last_bus <= '0;
    end else begin
      pc <= pc_d;
      if (start_ok) begin
        len     <= len_clamped;
        timeout <= 1'b0;
      end
      // A halt word never reaches the processor; iin keeps the last issued word.
      if ((state == ST_FETCH) && !is_halt) iin_q <= rd_data;
      if (state == ST_ISSUE)     cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + 8'd1;
      if ((state == ST_WAIT) && proc.done) last_bus <= proc.bus;
      // done on the final counter cycle wins over the timeout.
      if ((state == ST_WAIT) && !proc.done && cnt_expired) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: processor model with programmable done delay,
// scoreboard of issued words, table of program runs and timing sequences.
module tb_instr_feeder;
  import instr_feeder_pkg::*;

  localparam int AW  = 4;
  localparam int IW  = 16;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          timeout;
  logic [15:0]   last_bus;

  instr_feeder_if #(.IW(IW)) pif ();

  instr_feeder #(
    .AW        (AW),
    .IW        (IW),
    .HALT_WORD (16'hFFFF),
    .TIMEOUT   (TMO)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .prog_len (prog_len),
    .start    (start),
    .proc     (pif),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .timeout  (timeout),
    .last_bus (last_bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int run_count = 0;

  typedef struct packed {
    logic [IW-1:0] iin;
    logic [AW-1:0] pc;
  } issue_t;
  issue_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Processor model: done raised proc_delay cycles after the run cycle
  // (0 = same cycle as run, negative = never).
  int          proc_delay = 3;
  int          pend       = 0;
  int          bus_seq    = 0;
  logic [15:0] bus_sent   = '0;

  initial begin
    pif.done = 1'b0;
    pif.bus  = '0;
    forever begin
      @(negedge clock);
      pif.done = 1'b0;
      if (resetn) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus_seq++;
            pif.done = 1'b1;
            pif.bus  = 16'hB000 + 16'(bus_seq);
            bus_sent = pif.bus;
          end
        end
        if (pif.run === 1'b1) begin
          if (proc_delay == 0) pif.done = 1'b1;
          pend = (proc_delay > 0) ? proc_delay : 0;
        end
      end
    end
  end

  // Scoreboard monitor: every run pulse must match the next expected issue.
  always @(negedge clock) begin
    issue_t e;
    if (pif.run === 1'b1) begin
      run_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_run: got iin %h pc %0d, required no run", pif.iin, pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_iin", 32'(pif.iin), 32'(e.iin));
        check("sb_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [IW-1:0] w, input int p);
    issue_t e;
    e.iin = w;
    e.pc  = AW'(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (!halted && n < 500) begin
      tick();
      n++;
    end
    if (!halted) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: halted never rose within 500 cycles, required halted=1", name);
    end
  endtask

  task automatic run_prog(input logic [AW:0] len, input int delay, input string name);
    proc_delay = delay;
    prog_len   = len;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_halted(name);
  endtask

  typedef struct {
    logic [3:0][IW-1:0] w;
    logic [AW:0]        len;
    int                 delay;
    int                 runs;
    logic [AW-1:0]      pc_end;
    logic [IW-1:0]      iin_end;
    logic               to_end;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [IW-1:0] w0, w1, w2, w3, a0, a1;
    int base, n;

    w0 = mk_imm(OP_MVI, 3'd0, 9'h01C);
    w1 = mk_imm(OP_MVI, 3'd2, 9'h00A);
    w2 = mk_rr(OP_ADD, 3'd0, 3'd2);
    w3 = mk_rr(OP_MV, 3'd0, 3'd0);
    a0 = mk_rr(OP_SUB, 3'd1, 3'd2);
    a1 = mk_rr(OP_MV, 3'd3, 3'd4);

    vt[0] = '{w: {w3, w2, w1, w0},                len: 5'd4, delay: 3, runs: 4,
              pc_end: 4'd3, iin_end: 16'h8000, to_end: 1'b0};
    vt[1] = '{w: {16'h0000, 16'h2080, 16'hFFFF, 16'hA01C}, len: 5'd3, delay: 3, runs: 1,
              pc_end: 4'd1, iin_end: 16'hA01C, to_end: 1'b0};
    vt[2] = '{w: {16'h0004, 16'h0003, 16'h0002, 16'h0001}, len: 5'd0, delay: 3, runs: 0,
              pc_end: 4'd0, iin_end: 16'hA01C, to_end: 1'b0};
    vt[3] = '{w: {16'h0000, 16'h0000, a1, a0},    len: 5'd2, delay: 1, runs: 2,
              pc_end: 4'd1, iin_end: a1, to_end: 1'b0};
    vt[4] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h1357}, len: 5'd1, delay: 8, runs: 1,
              pc_end: 4'd0, iin_end: 16'h1357, to_end: 1'b0};
    vt[5] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h2468}, len: 5'd1, delay: 9, runs: 1,
              pc_end: 4'd0, iin_end: 16'h2468, to_end: 1'b1};
    vt[6] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h3579}, len: 5'd1, delay: 0, runs: 1,
              pc_end: 4'd0, iin_end: 16'h3579, to_end: 1'b1};
    vt[7] = '{w: {16'h0000, 16'h0000, 16'h4AAA, 16'h4555}, len: 5'd2, delay: 3, runs: 2,
              pc_end: 4'd1, iin_end: 16'h4AAA, to_end: 1'b0};

    resetn = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    prog_len = '0; start = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_iin", 32'(pif.iin), 32'h0);
    check("rst_run", 32'(pif.run), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_last_bus", 32'(last_bus), 32'h0);
    resetn = 1'b0;
    tick();

    // start-to-first-run latency and single-cycle run pulse
    load(4'd0, 16'h0C0C);
    push(16'h0C0C, 0);
    proc_delay = 3; prog_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_run_fetch", 32'(pif.run), 32'h0);
    check("lat_busy_fetch", 32'(busy), 32'h1);
    tick();
    check("lat_run_issue", 32'(pif.run), 32'h1);
    check("lat_iin_issue", 32'(pif.iin), 32'h0C0C);
    tick();
    check("lat_run_wait", 32'(pif.run), 32'h0);
    wait_halted("lat");

    // Table of program runs
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) load(AW'(k), vt[i].w[k]);
      for (int k = 0; k < vt[i].runs; k++) push(vt[i].w[k], k);
      base = run_count;
      run_prog(vt[i].len, vt[i].delay, $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d_runs", i), 32'(run_count - base), 32'(vt[i].runs));
      check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vt[i].pc_end));
      check($sformatf("vec%0d_iin", i), 32'(pif.iin), 32'(vt[i].iin_end));
      check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vt[i].to_end));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'h1);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      check($sformatf("vec%0d_sb_empty", i), 32'(exp_q.size()), 32'h0);
      if (!vt[i].to_end) check($sformatf("vec%0d_last_bus", i), 32'(last_bus), 32'(bus_sent));
    end

    // Exact timeout: TMO wait cycles after run, then rerun clears the flag
    load(4'd0, 16'h0707);
    push(16'h0707, 0);
    proc_delay = -1; prog_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("to_run", 32'(pif.run), 32'h1);
    repeat (TMO) tick();
    check("to_halted_early", 32'(halted), 32'h0);
    check("to_flag_early", 32'(timeout), 32'h0);
    tick();
    check("to_halted", 32'(halted), 32'h1);
    check("to_flag", 32'(timeout), 32'h1);
    push(16'h0707, 0);
    proc_delay = 3; start = 1'b1;
    tick();
    start = 1'b0;
    check("to_clear", 32'(timeout), 32'h0);
    check("to_rerun_pc", 32'(pc), 32'h0);
    wait_halted("to_rerun");
    check("to_rerun_flag", 32'(timeout), 32'h0);

    // Write while busy is dropped; rerun still issues the old word
    for (int k = 0; k < 4; k++) load(AW'(k), vt[0].w[k]);
    for (int k = 0; k < 4; k++) push(vt[0].w[k], k);
    proc_delay = 3; prog_len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    wait_halted("wbusy");
    for (int k = 0; k < 4; k++) push(vt[0].w[k], k);
    run_prog(5'd4, 3, "wbusy_rerun");
    check("wbusy_sb_empty", 32'(exp_q.size()), 32'h0);

    // Write and start in the same cycle: first fetch sees the new word
    push(16'h5555, 0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5555;
    prog_len = 5'd1; proc_delay = 3; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_halted("wstart");
    check("wstart_iin", 32'(pif.iin), 32'h5555);

    // prog_len above depth is clamped to the full RAM
    for (int k = 0; k < 16; k++) load(AW'(k), 16'h0100 + 16'(k));
    for (int k = 0; k < 16; k++) push(16'h0100 + 16'(k), k);
    base = run_count;
    run_prog(5'd31, 1, "clamp");
    check("clamp_runs", 32'(run_count - base), 32'd16);
    check("clamp_pc", 32'(pc), 32'd15);
    check("clamp_iin", 32'(pif.iin), 32'h010F);

    // Reset in the middle of WAIT at pc=2
    for (int k = 0; k < 4; k++) load(AW'(k), vt[0].w[k]);
    for (int k = 0; k < 4; k++) push(vt[0].w[k], k);
    proc_delay = 3; prog_len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pif.run === 1'b1 && pc == 4'd2) && n < 200) begin
      tick();
      n++;
    end
    check("mrst_reached_pc2", 32'(pc), 32'd2);
    tick();
    check("mrst_busy_before", 32'(busy), 32'h1);
    resetn = 1'b1;
    tick();
    check("mrst_iin", 32'(pif.iin), 32'h0);
    check("mrst_run", 32'(pif.run), 32'h0);
    check("mrst_pc", 32'(pc), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_halted", 32'(halted), 32'h0);
    check("mrst_timeout", 32'(timeout), 32'h0);
    check("mrst_last_bus", 32'(last_bus), 32'h0);
    exp_q.delete();
    resetn = 1'b0;
    repeat (12) tick();
    check("mrst_idle_busy", 32'(busy), 32'h0);
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
